mod_exp_ctrl: RTL and testbench
===============================

Name: mod_exp_ctrl

Overview:
- Sequencer that computes a Montgomery-domain modular exponentiation by driving the team's Montgomery multiply/square unit (the MM unit).
- The MM unit is the responder; this block is the initiator.
- It raises enable and presents pow_bit, multiplicand and indata, then waits for the MM unit's single-cycle endflag. It captures the result and walks the exponent MSB-first (left-to-right square-and-multiply).
- It sits between the RSA top-level register file and the MM unit. The modulus and mp are wired to the MM unit directly, not through this block.

Parameters:
- WIDTH, 256, operand/modulus width; must match the MM unit.
- EXP_WIDTH, 256, exponent width.
- TIMEOUT, 64, maximum cycles to wait for endflag per operation before aborting.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin exponentiation; sampled only in IDLE
- base_mont  input  WIDTH  base, already in Montgomery form
- one_mont  input  WIDTH  R mod N (Montgomery one)
- exponent  input  EXP_WIDTH  exponent
- busy  output  1  high from the cycle after accepted start until the DONE cycle
- done  output  1  one-cycle pulse when result is valid
- err  output  1  one-cycle pulse coincident with done on timeout
- result  output  WIDTH  final accumulator; held until the next start
- mm_enable  output  1  MM unit enable; low means MM reloads its operands
- mm_pow_bit  output  1  current exponent bit
- mm_multiplicand  output  WIDTH  accumulator (the value squared)
- mm_indata  output  WIDTH  latched base
- mm_endflag  input  1  MM completion pulse
- mm_result  input  WIDTH  MM result; valid while mm_endflag=1

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers cleared.
- All outputs are registered. mm_multiplicand = acc register; mm_indata = base register.
- IDLE:
  - start=1 latches base_mont, exponent and one_mont (acc <= one_mont); bit_idx <= EXP_WIDTH-1.
  - busy <= 1; go to LOAD.
- LOAD (mm_enable=0; the MM unit loads acc):
  - mm_pow_bit <= exp[bit_idx].
  - Go to RUN and set mm_enable <= 1.
- RUN:
  - Timeout counter increments each cycle.
  - On mm_endflag=1: acc <= mm_result; mm_enable <= 0; counter cleared.
    - If bit_idx==0, go to DONE.
    - Otherwise bit_idx <= bit_idx-1 and go to GAP.
  - If the counter reaches TIMEOUT-1 without endflag: mm_enable <= 0; err flag set; go to DONE.
  - mm_endflag in the same cycle as timeout: endflag wins, no error.
- GAP: exactly one cycle with mm_enable=0 and acc stable. mm_pow_bit <= exp[bit_idx]; go to RUN with mm_enable <= 1.
- DONE:
  - result <= acc; done=1 for one cycle; err=1 that same cycle if flagged; busy <= 0.
  - Next state IDLE.
- start while busy is ignored; the latched inputs do not change mid-run.
- mm_endflag outside RUN is ignored.
- Reset mid-operation: immediate return to IDLE with mm_enable=0; result cleared; no done pulse.
- Operation count without the optional feature is always EXP_WIDTH. An exponent of 0 yields one_mont after EXP_WIDTH squarings.

Optional Feature:
- Macro: MOD_EXP_LEADING_ZERO_SKIP_EN.
- Defined:
  - In LOAD on the first operation, bit_idx <= index of the highest set exponent bit.
  - If exponent==0, LOAD goes straight to DONE with result=one_mont and zero MM operations.
- Undefined: every bit from EXP_WIDTH-1 down to 0 is processed.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, LOAD, RUN, GAP, DONE);
  - WIDTH/EXP_WIDTH defaults;
  - TIMEOUT default.
- One natural sub-module: msb_index, a combinational priority encoder over EXP_WIDTH returning index and a zero flag. It is instantiated only under MOD_EXP_LEADING_ZERO_SKIP_EN.

Test Plan:
- Behavioral MM model (18-cycle latency, computes acc²·(bit?base:1) in plain modular arithmetic with R=1 for checking): exponent=0xB, base=3, one=1, N=1000003, skip enabled. Required: 4 mm_enable rising edges; mm_pow_bit sequence 1,0,1,1; result=177147; single done pulse; err=0.
- exponent=0, skip enabled: done 2 cycles after start; zero mm_enable pulses; result=one_mont. With skip disabled: exactly 256 operations and result=one_mont.
- Model never asserts endflag, TIMEOUT=64: mm_enable high for 64 cycles, then done=err=1 in the same cycle and busy drops.
- start re-asserted during RUN with different exponent: ignored; original result produced; one done pulse only.
- rst asserted mid-RUN: mm_enable, busy, done and result are 0 immediately (asynchronous). A subsequent start with exponent=0x5, base=2, N=1000003 gives result=32.
- endflag and timeout in the same cycle: acc captured, err=0, sequence continues.

Source files
------------

// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   state_t        : sequencer states (IDLE, LOAD, RUN, GAP, DONE)
//   DEF_WIDTH      : default operand / modulus width
//   DEF_EXP_WIDTH  : default exponent width
//   DEF_TIMEOUT    : default per-operation endflag wait limit, in cycles
package mod_exp_ctrl_pkg;

    localparam int unsigned DEF_WIDTH     = 256;
    localparam int unsigned DEF_EXP_WIDTH = 256;
    localparam int unsigned DEF_TIMEOUT   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_exp_ctrl_msb.sv
// msb_index: combinational priority encoder returning the position of the
// highest set bit of value. zero is high when no bit is set (index is 0 then).
//   value : input  [WIDTH-1:0]
//   index : output [$clog2(WIDTH)-1:0]
//   zero  : output
module msb_index #(
    parameter int unsigned WIDTH = 256
) (
    input  logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        index = '0;
        zero  = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                index = i[$clog2(WIDTH)-1:0];
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer driving the
// Montgomery multiply/square (MM) unit. Each exponent bit is one MM operation
// computing acc^2 * (bit ? base : 1); the accumulator starts at one_mont.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin exponentiation (sampled in IDLE only)
//   base_mont         : base in Montgomery form (latched on start)
//   one_mont          : R mod N, initial accumulator (latched on start)
//   exponent          : exponent (latched on start)
//   busy              : high from cycle after accepted start until DONE cycle
//   done, err         : one-cycle completion pulse; err marks an MM timeout
//   result            : final accumulator, held until next start
//   mm_enable         : MM enable; low makes the MM unit reload operands
//   mm_pow_bit        : current exponent bit
//   mm_multiplicand   : accumulator (value squared)
//   mm_indata         : latched base
//   mm_endflag        : MM single-cycle completion pulse
//   mm_result         : MM result, valid while mm_endflag=1
//
// Build option: define MOD_EXP_LEADING_ZERO_SKIP_EN to start at the highest
// set exponent bit (exponent 0 then finishes with no MM operations).
module mod_exp_ctrl
    import mod_exp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base_mont,
    input  logic [WIDTH-1:0]     one_mont,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mm_enable,
    output logic                 mm_pow_bit,
    output logic [WIDTH-1:0]     mm_multiplicand,
    output logic [WIDTH-1:0]     mm_indata,
    input  logic                 mm_endflag,
    input  logic [WIDTH-1:0]     mm_result
);

    localparam int unsigned IDX_W = $clog2(EXP_WIDTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [WIDTH-1:0]     acc, acc_n;
    logic [WIDTH-1:0]     base_val, base_n;
    logic [EXP_WIDTH-1:0] exp_val, exp_n;
    logic [IDX_W-1:0]     bit_idx, idx_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 err_flag, err_flag_n;
    logic                 busy_n, done_n, err_n, en_n, pow_n;
    logic [WIDTH-1:0]     result_n;

`ifdef MOD_EXP_LEADING_ZERO_SKIP_EN
    logic [IDX_W-1:0] msb_idx;
    logic             exp_zero;

    msb_index #(.WIDTH(EXP_WIDTH)) u_msb (
        .value (exp_val),
        .index (msb_idx),
        .zero  (exp_zero)
    );
`endif

    assign mm_multiplicand = acc;
    assign mm_indata       = base_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            base_val   <= '0;
            exp_val    <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
            err_flag   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            mm_enable  <= 1'b0;
            mm_pow_bit <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            base_val   <= base_n;
            exp_val    <= exp_n;
            bit_idx    <= idx_n;
            cnt        <= cnt_n;
            err_flag   <= err_flag_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            result     <= result_n;
            mm_enable  <= en_n;
            mm_pow_bit <= pow_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        base_n     = base_val;
        exp_n      = exp_val;
        idx_n      = bit_idx;
        cnt_n      = cnt;
        err_flag_n = err_flag;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;
        result_n   = result;
        en_n       = mm_enable;
        pow_n      = mm_pow_bit;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    base_n     = base_mont;
                    exp_n      = exponent;
                    acc_n      = one_mont;
                    idx_n      = IDX_TOP;
                    cnt_n      = '0;
                    err_flag_n = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef MOD_EXP_LEADING_ZERO_SKIP_EN
                if (exp_zero) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n   = msb_idx;
                    pow_n   = exp_val[msb_idx];
                    en_n    = 1'b1;
                    state_n = ST_RUN;
                end
`else
                pow_n   = exp_val[bit_idx];
                en_n    = 1'b1;
                state_n = ST_RUN;
`endif
            end
            ST_RUN: begin
                // endflag takes priority over a coinciding timeout
                if (mm_endflag) begin
                    acc_n = mm_result;
                    en_n  = 1'b0;
                    cnt_n = '0;
                    if (bit_idx == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = bit_idx - 1'b1;
                        state_n = ST_GAP;
                    end
                end else if (cnt == CNT_LAST) begin
                    en_n       = 1'b0;
                    cnt_n      = '0;
                    err_flag_n = 1'b1;
                    state_n    = ST_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                pow_n   = exp_val[bit_idx];
                en_n    = 1'b1;
                state_n = ST_RUN;
            end
            ST_DONE: begin
                result_n = acc;
                done_n   = 1'b1;
                err_n    = err_flag;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural MM responder
// (R = 1, plain modular arithmetic, prime modulus N).
module tb_mod_exp_ctrl;

    localparam int W  = 32;
    localparam int EW = 256;
    localparam int TO = 64;
    localparam longint N = 1000003;
`ifdef MOD_EXP_LEADING_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  base_mont = '0;
    logic [W-1:0]  one_mont = '0;
    logic [EW-1:0] exponent = '0;
    logic          busy, done, err, mm_enable, mm_pow_bit;
    logic [W-1:0]  result, mm_multiplicand, mm_indata;
    logic          mm_endflag = 1'b0;
    logic [W-1:0]  mm_result = '0;

    mod_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_mont(base_mont),
        .one_mont(one_mont), .exponent(exponent), .busy(busy), .done(done),
        .err(err), .result(result), .mm_enable(mm_enable),
        .mm_pow_bit(mm_pow_bit), .mm_multiplicand(mm_multiplicand),
        .mm_indata(mm_indata), .mm_endflag(mm_endflag), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- reference math ----------------
    function automatic longint modpow(input longint b, input longint e, input longint m);
        longint r = 1 % m;
        longint x = b % m;
        longint k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int msb_of(input logic [EW-1:0] e);
        int m = -1;
        for (int i = 0; i < EW; i++) if (e[i]) m = i;
        return m;
    endfunction

    function automatic int nops_of(input logic [EW-1:0] e);
        return SKIP ? msb_of(e) + 1 : EW;
    endfunction

    function automatic int top_of(input logic [EW-1:0] e);
        return SKIP ? msb_of(e) : EW - 1;
    endfunction

    function automatic int cyc_of(input int ops, input int lat);
        return (ops == 0) ? 2 : ops * (lat + 2) + 1;
    endfunction

    // one^(2^ops) * base^e mod N, reduced with Fermat since N is prime
    function automatic longint ref_result(input longint b, input longint one,
                                          input logic [EW-1:0] e, input int ops);
        logic [EW-1:0] m = EW'(N - 1);
        logic [EW-1:0] er = e % m;
        longint ered = longint'(er[62:0]);
        longint sq = modpow(2, longint'(ops), N - 1);
        return (modpow(one, sq, N) * modpow(b, ered, N)) % N;
    endfunction

    // ---------------- MM responder model ----------------
    int     lat = 18;
    bit     mute = 1'b0;
    int     ops = 0;
    bit     powq[$];
    bit     m_active = 1'b0;
    int     m_cnt = 0;
    longint m_a, m_b;
    bit     m_bit;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mm_endflag = 1'b0;
            if (!mm_enable) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_cnt = 0;
                m_a = longint'(mm_multiplicand);
                m_b = longint'(mm_indata);
                m_bit = mm_pow_bit;
                ops++;
                powq.push_back(mm_pow_bit);
            end else begin
                m_cnt++;
                if (m_cnt == lat && !mute) begin
                    mm_endflag = 1'b1;
                    mm_result = W'(((m_a * m_a) % N) * (m_bit ? m_b : 64'd1) % N);
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int     done_cnt = 0;
    int     err_alone = 0;
    int     en_hi = 0;
    longint last_res = 0;
    bit     last_err = 1'b0;
    bit     last_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                last_res = longint'(result);
                last_err = err;
                last_busy = busy;
            end
            if (err && !done) err_alone++;
            if (mm_enable) en_hi++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [EW-1:0] e, input longint b, input longint one);
        @(negedge clk);
        ops = 0;
        powq.delete();
        done_cnt = 0;
        err_alone = 0;
        en_hi = 0;
        exponent = e;
        base_mont = W'(b);
        one_mont = W'(one);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            #1;
            cycles++;
            if (done_cnt > 0) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [EW-1:0] e;
        longint        b;
        longint        one;
        int            lat;
        bit            mute;
        longint        x_res;
        bit            x_err;
        int            x_ops;
        int            x_cyc;
        int            x_en;   // required mm_enable-high cycles, -1 = not checked
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic [EW-1:0] e, input longint b, input longint one,
                           input int l, input bit mu, input longint xr, input bit xe,
                           input int xo, input int xc, input int xen);
        vec_t v;
        v.e = e; v.b = b; v.one = one; v.lat = l; v.mute = mu;
        v.x_res = xr; v.x_err = xe; v.x_ops = xo; v.x_cyc = xc; v.x_en = xen;
        vt.push_back(v);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  mism;
        int  s;
        logic [EW-1:0] e;
        longint b, one;
        int  l;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_mm_enable", mm_enable, 0);
        check("rst_mm_pow_bit", mm_pow_bit, 0);
        check("rst_multiplicand", mm_multiplicand, 0);
        rst = 1'b0;

        // vector table
        e = 256'hB;
        add_vec(e, 3, 1, 18, 0, 177147, 0, nops_of(e), cyc_of(nops_of(e), 18), -1);
        e = '0;
        add_vec(e, 5, 1, 18, 0, 1, 0, nops_of(e), cyc_of(nops_of(e), 18), -1);
        e = 256'hB;
        add_vec(e, 3, 1, 18, 1, 1, 1, 1, TO + 2, TO);          // MM never answers
        add_vec(e, 3, 1, 64, 0, 1, 1, 1, TO + 2, TO);          // answer one cycle too late
        add_vec(e, 3, 1, 63, 0, 177147, 0, nops_of(e), cyc_of(nops_of(e), 63), -1);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < EW / 32; j++) e[j*32 +: 32] = $urandom;
            e = e >> $urandom_range(0, 250);
            b = longint'($urandom_range(1, 1000002));
            one = longint'($urandom_range(1, 1000002));
            l = $urandom_range(1, 3);
            add_vec(e, b, one, l, 0, ref_result(b, one, e, nops_of(e)), 0,
                    nops_of(e), cyc_of(nops_of(e), l), -1);
        end

        foreach (vt[i]) begin
            lat = vt[i].lat;
            mute = vt[i].mute;
            start_op(vt[i].e, vt[i].b, vt[i].one);
            check($sformatf("v%0d_busy_after_start", i), busy, 1);
            wait_done(EW * (vt[i].lat + 4) + 200, cyc, ok);
            check($sformatf("v%0d_done_seen", i), ok, 1);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("v%0d_result", i), last_res, vt[i].x_res);
            check($sformatf("v%0d_err", i), last_err, vt[i].x_err);
            check($sformatf("v%0d_err_without_done", i), err_alone, 0);
            check($sformatf("v%0d_busy_at_done", i), last_busy, 0);
            check($sformatf("v%0d_ops", i), ops, vt[i].x_ops);
            check($sformatf("v%0d_latency", i), cyc, vt[i].x_cyc);
            if (vt[i].x_en >= 0)
                check($sformatf("v%0d_enable_cycles", i), en_hi, vt[i].x_en);
            mism = 0;
            s = top_of(vt[i].e);
            foreach (powq[k]) begin
                if (s - k < 0) mism++;
                else if (powq[k] != vt[i].e[s - k]) mism++;
            end
            check($sformatf("v%0d_pow_bit_seq", i), mism, 0);
        end

        // start re-asserted mid-run is ignored
        lat = 3;
        mute = 1'b0;
        e = 256'h2D;
        start_op(e, 7, 1);
        repeat (20) @(negedge clk);
        exponent = 256'h3;
        base_mont = 32'd11;
        one_mont = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(EW * 8 + 200, cyc, ok);
        check("restart_done_seen", ok, 1);
        check("restart_done_pulses", done_cnt, 1);
        check("restart_result", last_res, ref_result(7, 1, e, nops_of(e)));
        check("restart_ops", ops, nops_of(e));

        // asynchronous reset mid-run
        lat = 18;
        start_op(256'h5, 2, 1);
        repeat (30) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mm_enable", mm_enable, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_done", done_cnt, 0);
        start_op(256'h5, 2, 1);
        wait_done(EW * 22 + 200, cyc, ok);
        check("post_rst_done_seen", ok, 1);
        check("post_rst_result", last_res, 32);
        check("post_rst_err", last_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
